// File: rtl/frame_lmfc_sysref_gen.sv
// Frame / LMFC strobe generator with runtime frame length and K, plus subclass-1 SYSREF alignment.
// Optional build macro SYSREF_PHASE_CHECK_EN adds a sticky SYSREF phase-error check in continuous mode.
module frame_lmfc_sysref_gen #(
    parameter int FRAME_W = 4,
    parameter int K_W     = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FRAME_W-1:0] i_frame_len,
    input  logic [K_W-1:0]     i_K,
    input  logic               i_sysref,
    input  logic               i_sysref_mode,
    input  logic               i_sysref_arm,
    input  logic [K_W-1:0]     i_lmfc_offset,
    output logic               o_frame_clk,
    output logic               o_lmfc_clk,
    output logic [K_W-1:0]     o_frame_idx,
    output logic               o_aligned,
    output logic               o_sysref_err
);

    logic [FRAME_W-1:0] beat_cnt;
    logic [K_W-1:0]     frame_idx;
    logic               sysref_q;
    logic               armed;

    logic               frame_wrap;
    logic [FRAME_W-1:0] beat_free;
    logic [K_W-1:0]     idx_free;
    logic [K_W-1:0]     idx_load;
    logic               sysref_edge;
    logic               armed_eff;
    logic               accept;

    // The >= compares keep both counters bounded when the config shrinks mid-run.
    function automatic logic beat_at_end(input logic [FRAME_W-1:0] beat,
                                         input logic [FRAME_W-1:0] len);
        return (beat >= len);
    endfunction

    function automatic logic [FRAME_W-1:0] next_beat(input logic [FRAME_W-1:0] beat,
                                                     input logic               wrap);
        return wrap ? '0 : beat + FRAME_W'(1);
    endfunction

    function automatic logic [K_W-1:0] next_idx(input logic [K_W-1:0] idx,
                                                input logic [K_W-1:0] k,
                                                input logic           wrap);
        logic [K_W-1:0] nxt;
        nxt = idx;
        if (wrap) begin
            nxt = (idx >= k) ? '0 : idx + K_W'(1);
        end
        return nxt;
    endfunction

    function automatic logic [K_W-1:0] load_idx(input logic [K_W-1:0] offset,
                                                input logic [K_W-1:0] k);
        return (offset > k) ? '0 : offset;
    endfunction

    always_comb begin
        frame_wrap  = beat_at_end(beat_cnt, i_frame_len);
        beat_free   = next_beat(beat_cnt, frame_wrap);
        idx_free    = next_idx(frame_idx, i_K, frame_wrap);
        idx_load    = load_idx(i_lmfc_offset, i_K);
        sysref_edge = i_sysref && !sysref_q;
        // An arm pulse takes effect before a coincident edge is judged.
        armed_eff   = armed || i_sysref_arm;
        accept      = sysref_edge && (i_sysref_mode || armed_eff);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt    <= '0;
            frame_idx   <= '0;
            sysref_q    <= 1'b1;
            armed       <= 1'b1;
            o_frame_clk <= 1'b0;
            o_lmfc_clk  <= 1'b0;
            o_frame_idx <= '0;
            o_aligned   <= 1'b0;
        end else begin
            sysref_q    <= i_sysref;
            o_frame_clk <= (beat_cnt == '0);
            o_lmfc_clk  <= (beat_cnt == '0) && (frame_idx == '0);
            o_frame_idx <= frame_idx;
            if (accept) begin
                beat_cnt  <= '0;
                frame_idx <= idx_load;
                o_aligned <= 1'b1;
                armed     <= 1'b0;
            end else begin
                beat_cnt  <= beat_free;
                frame_idx <= idx_free;
                armed     <= armed_eff;
                if (i_sysref_arm) begin
                    o_aligned <= 1'b0;
                end
            end
        end
    end

`ifdef SYSREF_PHASE_CHECK_EN
    logic phase_check;
    logic phase_err;

    // Only an already-aligned continuous link is checked; an arm in the same cycle drops alignment first.
    always_comb begin
        phase_check = accept && i_sysref_mode && o_aligned && !i_sysref_arm;
        phase_err   = phase_check && ((beat_free != '0) || (idx_free != idx_load));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_sysref_err <= 1'b0;
        end else if (i_sysref_arm) begin
            o_sysref_err <= 1'b0;
        end else if (phase_err) begin
            o_sysref_err <= 1'b1;
        end
    end
`else
    assign o_sysref_err = 1'b0;
`endif

endmodule

// File: tb/tb_frame_lmfc_sysref_gen.sv
// Scoreboard bench for frame_lmfc_sysref_gen: a cycle model predicts every output, plus directed anchors.
module tb_frame_lmfc_sysref_gen;
    localparam int FRAME_W = 4;
    localparam int K_W     = 5;
    localparam int OW      = K_W + 4;
`ifdef SYSREF_PHASE_CHECK_EN
    localparam bit PHASE = 1'b1;
`else
    localparam bit PHASE = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [FRAME_W-1:0] frame_len = '0;
    logic [K_W-1:0]     k = '0;
    logic               sysref = 1'b0;
    logic               sysref_mode = 1'b0;
    logic               sysref_arm = 1'b0;
    logic [K_W-1:0]     lmfc_offset = '0;
    logic               o_frame_clk, o_lmfc_clk, o_aligned, o_sysref_err;
    logic [K_W-1:0]     o_frame_idx;

    int checks = 0;
    int errors = 0;
    logic [OW-1:0] sb_q[$];

    int m_beat, m_idx, m_fidx;
    bit m_sq, m_armed, m_fclk, m_lclk, m_al, m_err;

    frame_lmfc_sysref_gen #(.FRAME_W(FRAME_W), .K_W(K_W)) dut (
        .clk(clk), .rst(rst), .i_frame_len(frame_len), .i_K(k),
        .i_sysref(sysref), .i_sysref_mode(sysref_mode), .i_sysref_arm(sysref_arm),
        .i_lmfc_offset(lmfc_offset), .o_frame_clk(o_frame_clk), .o_lmfc_clk(o_lmfc_clk),
        .o_frame_idx(o_frame_idx), .o_aligned(o_aligned), .o_sysref_err(o_sysref_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Reference model of one clock, using the inputs currently applied.
    task automatic model_tick();
        int nb, ni, ld;
        bit edge_s, acc;
        if (rst) begin
            m_beat = 0; m_idx = 0; m_sq = 1'b1; m_armed = 1'b1;
            m_fclk = 1'b0; m_lclk = 1'b0; m_fidx = 0; m_al = 1'b0; m_err = 1'b0;
        end else begin
            edge_s = sysref && !m_sq;
            if (sysref_arm) begin
                m_armed = 1'b1; m_al = 1'b0; m_err = 1'b0;
            end
            acc    = edge_s && (sysref_mode || m_armed);
            m_fclk = (m_beat == 0);
            m_lclk = (m_beat == 0) && (m_idx == 0);
            m_fidx = m_idx;
            if (m_beat >= int'(frame_len)) begin
                nb = 0;
                ni = (m_idx >= int'(k)) ? 0 : m_idx + 1;
            end else begin
                nb = m_beat + 1;
                ni = m_idx;
            end
            ld = (int'(lmfc_offset) > int'(k)) ? 0 : int'(lmfc_offset);
            if (acc) begin
                if (PHASE && sysref_mode && m_al && (nb != 0 || ni != ld)) m_err = 1'b1;
                m_beat = 0; m_idx = ld; m_al = 1'b1; m_armed = 1'b0;
            end else begin
                m_beat = nb; m_idx = ni;
            end
            m_sq = sysref;
        end
        sb_q.push_back({m_fclk, m_lclk, K_W'(m_fidx), m_al, m_err});
    endtask

    task automatic step();
        logic [OW-1:0] exp;
        model_tick();
        @(posedge clk);
        #1;
        exp = sb_q.pop_front();
        check("sb", {o_frame_clk, o_lmfc_clk, o_frame_idx, o_aligned, o_sysref_err}, exp);
    endtask

    initial begin
        int nf, nl;
        bit found;

        // Free-run after reset: frame every 2, LMFC every 8
        rst = 1'b1; frame_len = 4'd1; k = 5'd3;
        step();
        rst = 1'b0;
        check("rst_state", {o_frame_clk, o_lmfc_clk, o_frame_idx, o_aligned, o_sysref_err}, 0);
        nf = 0; nl = 0;
        repeat (16) begin
            step();
            nf += int'(o_frame_clk);
            nl += int'(o_lmfc_clk);
        end
        check("t1_frames", nf, 8);
        check("t1_lmfcs", nl, 2);

        // One-shot alignment, second rise ignored
        frame_len = 4'd3; k = 5'd1; lmfc_offset = '0; sysref_mode = 1'b0;
        sysref_arm = 1'b1; step(); sysref_arm = 1'b0;
        repeat (3) step();
        sysref = 1'b1; step();
        check("t2_aligned", o_aligned, 1);
        sysref = 1'b0; step();
        check("t2_lmfc_n2", o_lmfc_clk, 1);
        nl = 0;
        for (int j = 2; j <= 9; j++) begin
            sysref = (j == 5);
            step();
            if (j < 9) nl += int'(o_lmfc_clk);
        end
        check("t2_lmfc_gap", nl, 0);
        check("t2_lmfc_n10", o_lmfc_clk, 1);

        // Continuous mode with LMFC offset 2
        sysref = 1'b0; sysref_mode = 1'b1; lmfc_offset = 5'd2; k = 5'd3; frame_len = 4'd1;
        repeat (3) step();
        sysref = 1'b1; step();
        sysref = 1'b0; step();
        check("t3_idx", {o_frame_clk, o_frame_idx}, {1'b1, 5'd2});
        nl = 0;
        for (int j = 2; j <= 5; j++) begin
            step();
            if (j < 5) nl += int'(o_lmfc_clk);
        end
        check("t3_lmfc_gap", nl, 0);
        check("t3_lmfc_n6", o_lmfc_clk, 1);

        // SYSREF high through reset is no edge; arm with rise aligns
        sysref = 1'b1; rst = 1'b1; step(); rst = 1'b0;
        check("t4_rst_mid", {o_frame_clk, o_lmfc_clk, o_frame_idx, o_aligned}, 0);
        repeat (6) step();
        check("t4_no_align", o_aligned, 0);
        sysref_mode = 1'b0; lmfc_offset = '0;
        sysref = 1'b0; step();
        sysref = 1'b1; step();
        check("t4_first", o_aligned, 1);
        sysref = 1'b0; step();
        sysref = 1'b1; sysref_arm = 1'b1; step(); sysref_arm = 1'b0;
        check("t4_arm_edge", o_aligned, 1);
        sysref = 1'b0; step();
        sysref = 1'b1; step();
        sysref = 1'b0;
        repeat (4) step();

        // Periodic SYSREF in continuous mode, then one shifted by a clock
        frame_len = 4'd7; k = 5'd1; sysref_mode = 1'b1; lmfc_offset = '0;
        sysref_arm = 1'b1; step(); sysref_arm = 1'b0;
        for (int t = 0; t < 100; t++) begin
            sysref = (t == 0 || t == 16 || t == 32 || t == 48 || t == 65);
            step();
            if (t == 60) check("t5_err_clean", o_sysref_err, 0);
            if (t == 66) check("t5_realign", o_lmfc_clk, 1);
        end
        sysref = 1'b0;
        check("t5_err_sticky", o_sysref_err, PHASE);

        // Shrink K mid-multiframe
        frame_len = 4'd1; k = 5'd7; sysref_mode = 1'b0;
        found = 1'b0;
        for (int j = 0; j < 40 && !found; j++) begin
            step();
            if (m_idx == 5) found = 1'b1;
        end
        check("t6_reach5", found, 1);
        k = 5'd2;
        found = 1'b0;
        for (int j = 0; j < 8 && !found; j++) begin
            step();
            if (o_frame_clk && o_frame_idx != 5'd5) found = 1'b1;
        end
        check("t6_boundary", found, 1);
        check("t6_wrap", o_frame_idx, 0);
        repeat (6) step();

        // Degenerate config: both strobes held high
        frame_len = '0; k = '0;
        repeat (2) step();
        repeat (4) begin
            step();
            check("t7_const", {o_frame_clk, o_lmfc_clk}, 2'b11);
        end
        sysref_mode = 1'b1;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/frame_lmfc_sysref_gen.md
Name: frame_lmfc_sysref_gen

Overview:
Parametrised successor to the fixed divide-by-2 frame/LMFC generator. Generates one-cycle frame and LMFC strobes with a runtime-programmable frame length (device clocks per frame) and K (frames per multiframe). Adds JESD204B subclass-1 SYSREF alignment (one-shot or continuous) with a programmable LMFC offset. Sits in the control path and feeds the link layer's ILAS/alignment logic and the deterministic-latency release logic.

Parameters:
FRAME_W, 4, width of i_frame_len; frame period up to 2^FRAME_W device clocks
K_W, 5, width of i_K, i_lmfc_offset and o_frame_idx; K up to 2^K_W frames

Ports:
clk  input  1  device clock
rst  input  1  synchronous reset, active-high
i_frame_len  input  FRAME_W  device clocks per frame, minus 1 (0 = 1 clock/frame)
i_K  input  K_W  frames per multiframe, minus 1
i_sysref  input  1  SYSREF, already synchronous to clk
i_sysref_mode  input  1  0 = one-shot, 1 = continuous
i_sysref_arm  input  1  one-cycle pulse; re-arms one-shot capture, clears o_aligned/o_sysref_err
i_lmfc_offset  input  K_W  frame index loaded on SYSREF alignment
o_frame_clk  output  1  one-cycle strobe per frame
o_lmfc_clk  output  1  one-cycle strobe per multiframe, coincident with frame 0's o_frame_clk
o_frame_idx  output  K_W  frame index within multiframe, registered alongside strobes
o_aligned  output  1  SYSREF edge accepted since last rst/arm
o_sysref_err  output  1  sticky phase error (0 unless SYSREF_PHASE_CHECK_EN)

Behaviour:
- Internal state: beat_cnt (FRAME_W), frame_idx (K_W), sysref_q, armed flag.
- Reset values: beat_cnt=0, frame_idx=0, sysref_q=1 (SYSREF held high through reset is not an edge), armed=1, all outputs 0.
- Free-run each cycle: if beat_cnt >= i_frame_len, beat_cnt<=0 and frame_idx advances; otherwise beat_cnt+1. Frame advance: if frame_idx >= i_K, frame_idx<=0, else +1. The >= compares keep the counters bounded when config shrinks mid-run.
- Outputs registered, latency 1: o_frame_clk(n+1) = (beat_cnt(n)==0); o_lmfc_clk(n+1) = (beat_cnt(n)==0 && frame_idx(n)==0); o_frame_idx(n+1) = frame_idx(n).
- i_frame_len=0: o_frame_clk stays high continuously. i_frame_len=0 and i_K=0: o_lmfc_clk also stays high continuously.
- Edge detect: edge(n) = i_sysref(n) && !sysref_q(n); sysref_q <= i_sysref every cycle.
- Accept: continuous mode, every edge; one-shot mode, an edge only while armed.
- Accepted edge in cycle n: beat_cnt(n+1)=0; frame_idx(n+1)=i_lmfc_offset, or 0 if i_lmfc_offset > i_K; o_aligned(n+1)=1; armed cleared.
- Deterministic latency: SYSREF rise at cycle n with offset 0 gives o_lmfc_clk high at n+2.
- i_sysref_arm: sets armed, clears o_aligned and o_sysref_err. Arm and edge in the same cycle: arm is applied first, then the edge is accepted, so the cycle ends with o_aligned=1 and armed=0.
- rst mid-operation returns everything to reset values in one cycle. Counters keep running from 0 with no SYSREF required.
- Changing i_sysref_mode only affects acceptance of later edges, never the current counters.

Optional Feature:
SYSREF_PHASE_CHECK_EN
- Defined: in continuous mode with o_aligned=1, each accepted edge compares the free-run next values of beat_cnt/frame_idx with the load values. On mismatch, o_sysref_err is set (sticky until rst/arm) and the counters are realigned. On match, counters continue unchanged.
- Undefined: o_sysref_err is tied 0; edges realign without checking.

Test Plan:
- rst, i_frame_len=1, i_K=3, no SYSREF -> o_frame_clk every 2 clks, o_lmfc_clk every 8 clks, o_frame_idx cycles 0..3.
- i_frame_len=3, i_K=1, offset 0, one-shot: SYSREF rise at cycle 100 -> o_lmfc_clk at 102 and 110; o_aligned=1 from 101. Second rise at 105 is ignored.
- Continuous mode, offset 2, i_K=3, i_frame_len=1: SYSREF rise at n -> o_frame_idx=2 with o_frame_clk at n+2, o_lmfc_clk at n+6.
- i_sysref high through rst deassert -> no alignment, o_aligned stays 0. Pulse arm together with a rise -> o_aligned=1 next cycle.
- SYSREF_PHASE_CHECK_EN, continuous, period 8: SYSREF every 16 clks -> o_sysref_err=0. Shift one SYSREF by 1 clk -> o_sysref_err=1 (sticky), LMFC realigned to new edge.
- i_K reduced from 7 to 2 while frame_idx=5 -> frame_idx wraps to 0 at next frame boundary, with no count past 7.
